// File: rtl/data_port_pkg.sv
// Shared defaults and sizing helper for the data port buffer.
package data_port_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to hold a word count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_port_ram.sv
// Buffer storage: DEPTH x WIDTH, one synchronous write port, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the owner.
module data_port_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Write the offered word into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_port_buf.sv
// Bus-side input buffer for one data port: a show-ahead FIFO between the
// bus (push on data_on_bus) and the router (pop on fwd).
// Optional feature: define DATA_PORT_BUF_ERR_EN to add the sticky err output,
// flagging a push dropped while full or a fwd issued while empty.
module data_port_buf
    import data_port_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         data_on_bus,
    output logic                         ready,
    output logic [WIDTH-1:0]             data_out,
    output logic                         out_valid,
    input  logic                         fwd,
    output logic [cnt_width(DEPTH)-1:0]  count
`ifdef DATA_PORT_BUF_ERR_EN
    ,
    output logic                         err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data;
    logic             push;
    logic             pop;

    // Handshake is purely from registered occupancy, so ready/out_valid
    // never depend combinationally on data_on_bus or fwd.
    assign ready     = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = data_on_bus && ready;
    assign pop       = fwd && out_valid;
    assign count     = count_q;
    assign data_out  = out_valid ? rd_data : '0;

    data_port_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a
    // power of two. Reset wins over any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef DATA_PORT_BUF_ERR_EN
    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err <= 1'b0;
        else if ((data_on_bus && !ready) || (fwd && !out_valid))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_data_port_buf.sv
// Self-checking bench for data_port_buf: directed vector table for the
// corner cases, then randomized traffic against a queue-based model.
module tb_data_port_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic             data_on_bus;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             fwd;
    logic [CW-1:0]    count;
`ifdef DATA_PORT_BUF_ERR_EN
    logic             err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_port_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_on_bus (data_on_bus),
        .ready       (ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .fwd         (fwd),
        .count       (count)
`ifdef DATA_PORT_BUF_ERR_EN
        ,
        .err         (err)
`endif
    );

    typedef struct {
        logic             rst_n;
        logic             bus;
        logic             fwd;
        logic [WIDTH-1:0] din;
        int               exp_count;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_out;
        logic             exp_ready;
        logic             exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic b, logic f, logic [WIDTH-1:0] d,
                                int c, logic v, logic [WIDTH-1:0] o, logic rd, logic e);
        vec_t t;
        t.rst_n = r; t.bus = b; t.fwd = f; t.din = d;
        t.exp_count = c; t.exp_valid = v; t.exp_out = o; t.exp_ready = rd; t.exp_err = e;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic v,
                             input logic [WIDTH-1:0] o, input logic rd, input logic e);
        chk({tag, " count"},     longint'(count),     longint'(c));
        chk({tag, " out_valid"}, longint'(out_valid), longint'(v));
        chk({tag, " data_out"},  longint'(data_out),  longint'(o));
        chk({tag, " ready"},     longint'(ready),     longint'(rd));
`ifdef DATA_PORT_BUF_ERR_EN
        chk({tag, " err"},       longint'(err),       longint'(e));
`else
        if (e === 1'bx) chk({tag, " err"}, 0, 1);
`endif
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic b, input logic f, input logic [WIDTH-1:0] d);
        rst_n = r; data_on_bus = b; fwd = f; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic             m_err;

    initial begin
        rst_n = 1'b0; data_on_bus = 1'b0; fwd = 1'b0; data_in = '0;

        // Reset and idle
        tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00,1,0));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00,1,0));
        // Fill to full, fifth push dropped
        tbl.push_back(mk(1,1,0,8'h11, 1,1,8'h11,1,0));
        tbl.push_back(mk(1,1,0,8'h22, 2,1,8'h11,1,0));
        tbl.push_back(mk(1,1,0,8'h33, 3,1,8'h11,1,0));
        tbl.push_back(mk(1,1,0,8'h44, 4,1,8'h11,0,0));
        tbl.push_back(mk(1,1,0,8'h55, 4,1,8'h11,0,1));
        // Drain in order
        tbl.push_back(mk(1,0,1,8'h00, 3,1,8'h22,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 2,1,8'h33,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 1,1,8'h44,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 0,0,8'h00,1,1));
        // Count 2, then simultaneous push/pop across pointer wrap
        tbl.push_back(mk(1,1,0,8'h01, 1,1,8'h01,1,1));
        tbl.push_back(mk(1,1,0,8'h02, 2,1,8'h01,1,1));
        tbl.push_back(mk(1,1,1,8'h03, 2,1,8'h02,1,1));
        tbl.push_back(mk(1,1,1,8'h04, 2,1,8'h03,1,1));
        tbl.push_back(mk(1,1,1,8'h05, 2,1,8'h04,1,1));
        tbl.push_back(mk(1,1,1,8'h06, 2,1,8'h05,1,1));
        tbl.push_back(mk(1,1,1,8'h07, 2,1,8'h06,1,1));
        tbl.push_back(mk(1,1,1,8'h08, 2,1,8'h07,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 1,1,8'h08,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 0,0,8'h00,1,1));
        // Empty with push and fwd: push only
        tbl.push_back(mk(1,1,1,8'hA5, 1,1,8'hA5,1,1));
        tbl.push_back(mk(1,1,0,8'h10, 2,1,8'hA5,1,1));
        tbl.push_back(mk(1,1,0,8'h20, 3,1,8'hA5,1,1));
        // Reset overrides push and pop
        tbl.push_back(mk(0,1,1,8'h99, 0,0,8'h00,1,0));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00,1,0));
        // Full plus fwd plus bus: pop only, ready rises after the edge
        tbl.push_back(mk(1,1,0,8'hB1, 1,1,8'hB1,1,0));
        tbl.push_back(mk(1,1,0,8'hB2, 2,1,8'hB1,1,0));
        tbl.push_back(mk(1,1,0,8'hB3, 3,1,8'hB1,1,0));
        tbl.push_back(mk(1,1,0,8'hB4, 4,1,8'hB1,0,0));
        tbl.push_back(mk(1,1,1,8'hC5, 3,1,8'hB2,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 2,1,8'hB3,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 1,1,8'hB4,1,1));
        tbl.push_back(mk(1,0,1,8'h00, 0,0,8'h00,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].bus, tbl[i].fwd, tbl[i].din);
            check_all($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_valid,
                      tbl[i].exp_out, tbl[i].exp_ready, tbl[i].exp_err);
        end

        // Randomized traffic against a queue model
        step(0, 0, 0, '0);
        mq.delete();
        m_err = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic             r, b, f, do_push, do_pop;
            logic [WIDTH-1:0] d;
            logic [WIDTH-1:0] head;
            r = ($urandom_range(0, 99) != 0);
            b = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 99) < 50);
            d = WIDTH'($urandom);
            step(r, b, f, d);
            if (!r) begin
                mq.delete();
                m_err = 1'b0;
            end else begin
                do_push = b && (mq.size() < DEPTH);
                do_pop  = f && (mq.size() > 0);
                if ((b && !do_push) || (f && !do_pop)) m_err = 1'b1;
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(d);
            end
            head = (mq.size() > 0) ? mq[0] : '0;
            check_all($sformatf("rnd%0d", n), mq.size(), mq.size() > 0, head,
                      mq.size() < DEPTH, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
